// File: rtl/calc_op_sequencer.sv
// Button-stepped sequencer: loads operands A/B, launches the ALU, waits (bounded) and holds the result.
// Optional CALC_ACCUMULATE_EN: a press in an error-free DONE writes the result back as operand A.
module calc_op_sequencer #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          clear,
  input  logic          next,
  input  logic [DW-1:0] din,
  input  logic [2:0]    ms,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result,
  output logic          rf_we,
  output logic          rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          alu_start,
  output logic [2:0]    ms_out,
  output logic [DW-1:0] result,
  output logic          done_out,
  output logic          err_out,
  output logic [2:0]    cs_out
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE1 = 3'd0,
    LOAD1 = 3'd1,
    IDLE2 = 3'd2,
    LOAD2 = 3'd3,
    IDLE3 = 3'd4,
    ISSUE = 3'd5,
    WAIT  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t        state;
  logic          next_q;
  logic [CW-1:0] cnt;
  logic          nedge;
  logic          ms_ok;

  assign nedge  = next & ~next_q;
  assign ms_ok  = (ms >= 3'd1) && (ms <= 3'd4);
  assign cs_out = state;

  always_ff @(posedge CLK) begin
    if (clear) begin
      // next_q starts high so a button held through reset needs a fresh press
      state     <= IDLE1;
      next_q    <= 1'b1;
      cnt       <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= 1'b0;
      rf_wdata  <= '0;
      alu_start <= 1'b0;
      ms_out    <= '0;
      result    <= '0;
      done_out  <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      next_q    <= next;
      rf_we     <= 1'b0;
      alu_start <= 1'b0;
      case (state)
        IDLE1: if (nedge) begin
          rf_wdata <= din;
          rf_waddr <= 1'b0;
          rf_we    <= 1'b1;
          state    <= LOAD1;
        end
        LOAD1: state <= IDLE2;
        IDLE2: if (nedge) begin
          rf_wdata <= din;
          rf_waddr <= 1'b1;
          rf_we    <= 1'b1;
          state    <= LOAD2;
        end
        LOAD2: state <= IDLE3;
        IDLE3: if (nedge) begin
          if (ms_ok) begin
            ms_out    <= ms;
            alu_start <= 1'b1;
            state     <= ISSUE;
          end else begin
            result   <= '0;
            err_out  <= 1'b1;
            done_out <= 1'b1;
            state    <= DONE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a result arriving on the last allowed cycle still beats the timeout
          if (alu_done) begin
            result   <= alu_result;
            err_out  <= 1'b0;
            done_out <= 1'b1;
            state    <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            result   <= '0;
            err_out  <= 1'b1;
            done_out <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (nedge) begin
`ifdef CALC_ACCUMULATE_EN
          if (!err_out) begin
            rf_wdata <= result;
            rf_waddr <= 1'b0;
            rf_we    <= 1'b1;
            result   <= '0;
            done_out <= 1'b0;
            ms_out   <= '0;
            state    <= IDLE2;
          end else begin
            result   <= '0;
            done_out <= 1'b0;
            err_out  <= 1'b0;
            ms_out   <= '0;
            state    <= IDLE1;
          end
`else
          result   <= '0;
          done_out <= 1'b0;
          err_out  <= 1'b0;
          ms_out   <= '0;
          state    <= IDLE1;
`endif
        end
        default: state <= IDLE1;
      endcase
    end
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Button-driven sequencer for the calculator datapath.
- Collects operand A, operand B and mode select from switches on successive presses of next.
- Writes operands into the two-entry register file, launches the ALU with a start/done handshake, waits (bounded) for a multi-cycle result and presents it with a done flag.
- Replaces the free-running level-sensitive controller with a fully synchronous one.

Parameters:
- DW, 8, operand/result data width
- TIMEOUT, 64, max cycles spent waiting for alu_done before error abort (>=2)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- clear  in  1  synchronous active-high reset
- next  in  1  user step button, already synchronised level; rising edge detected internally
- din  in  DW  switch data for operands
- ms  in  3  mode select: 1 add, 2 sub, 3 mul, 4 xor; 0,5,6,7 invalid
- alu_done  in  1  ALU result valid pulse
- alu_result  in  DW  ALU result, valid when alu_done=1
- rf_we  out  1  register file write enable
- rf_waddr  out  1  register file write address (0 = operand A, 1 = operand B)
- rf_wdata  out  DW  register file write data
- alu_start  out  1  one-cycle ALU launch pulse
- ms_out  out  3  latched mode to ALU
- result  out  DW  latched result
- done_out  out  1  result valid
- err_out  out  1  invalid mode or ALU timeout
- cs_out  out  3  current state encoding, for LEDs

Behaviour:
- Reset (clear=1 at a CLK edge):
  - State goes to IDLE1; every output is 0; timeout counter is 0.
  - next_q (edge register) is set to 1, so a button held through reset produces no edge until it is released and pressed again.
  - clear overrides every other input in the same cycle, in any state including mid-WAIT.
- Edge detection: nedge = next & ~next_q; next_q <= next every cycle.
- States and cs_out encoding: IDLE1=0, LOAD1=1, IDLE2=2, LOAD2=3, IDLE3=4, ISSUE=5, WAIT=6, DONE=7.
- All outputs are registered.
- IDLE1 --nedge--> LOAD1; din captured into rf_wdata on the edge cycle.
- LOAD1: rf_we=1, rf_waddr=0 for exactly one cycle -> IDLE2.
- IDLE2 --nedge--> LOAD2; din captured.
- LOAD2: rf_we=1, rf_waddr=1 for one cycle -> IDLE3.
- IDLE3 --nedge--> ms sampled:
  - ms in 1..4: ms_out latched, go to ISSUE.
  - otherwise: go to DONE with err_out=1, result=0, no alu_start.
- ISSUE: alu_start=1 for one cycle; counter cleared -> WAIT.
- WAIT: alu_done is sampled only in this state; an alu_done coinciding with the ISSUE cycle is ignored.
  - alu_done=1: result <= alu_result -> DONE.
  - Else counter increments. When counter reaches TIMEOUT-1 without alu_done -> DONE with err_out=1, result=0.
  - alu_done on the final cycle wins over timeout.
- DONE: done_out=1; result, err_out and ms_out held. nedge -> IDLE1 with done_out, err_out, result and ms_out cleared.
- Latency:
  - Press to rf_we: 1 cycle after the nedge cycle.
  - alu_done to done_out: 1 cycle.
- nedge in LOAD1, LOAD2, ISSUE and WAIT is dropped (not queued).
- ms_out is stable from ISSUE through DONE; changes on the ms switches after capture have no effect.
- rf_wdata holds its last value when rf_we=0.
- alu_done or alu_result activity outside WAIT is ignored.

Optional Feature:
- Macro: CALC_ACCUMULATE_EN.
- Defined:
  - nedge in DONE with err_out=0 performs rf_we=1, rf_waddr=0, rf_wdata=result for one cycle, then enters IDLE2.
  - done_out and result clear on that write cycle.
  - The result becomes operand A for a chained operation.
  - With err_out=1, DONE returns to IDLE1 as normal.
- Undefined: DONE always returns to IDLE1; no write-back path is synthesised.

Test Plan:
- Add: din=5 press, din=3 press, ms=1 press; ALU model returns done 1 cycle after start with 8 -> rf writes (0,5) then (1,3); alu_start single pulse, ms_out=1; done_out=1, result=8, err_out=0, cs_out=7.
- Mul, slow ALU (done 10 cycles after start, 5*3=15), extra next presses during WAIT -> presses ignored; result=15; one alu_start only; state stays DONE until next press, then IDLE1 with outputs cleared.
- Timeout, TIMEOUT=16, alu_done never asserted -> DONE exactly 16 cycles after WAIT entry, err_out=1, result=0; also alu_done on cycle 16 -> err_out=0 and result is taken from the ALU.
- Invalid mode ms=6 at third press -> no alu_start, done_out=1, err_out=1; next press -> IDLE1, err_out=0.
- clear asserted mid-WAIT, then alu_done one cycle later -> state IDLE1, all outputs 0, late done ignored. next held high through clear release -> no transition until release and re-press.
- CALC_ACCUMULATE_EN build: after add result 8, press -> rf write (0,8), cs_out=2; then din=2, ms=2 (sub) -> result=6.
